// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the integer writeback stage: thread and vector
// types, the decoded-instruction record carried down the pipeline, and
// the branch-type encoding used to recognise calls.
package writeback_stage_pkg;

  localparam int THREADS_PER_CORE = 4;
  localparam int VECTOR_LANES     = 16;
  localparam int THREAD_IDX_W     = $clog2(THREADS_PER_CORE);

  typedef logic [THREAD_IDX_W-1:0]       thread_idx_t;
  typedef logic [31:0]                   scalar_t;
  typedef logic [VECTOR_LANES-1:0][31:0] vector_t;
  typedef logic [VECTOR_LANES-1:0]       vector_mask_t;

  typedef enum logic [2:0] {
    BRANCH_COND_ZERO,
    BRANCH_COND_NONZERO,
    BRANCH_ALWAYS,
    BRANCH_CALL_OFFSET,
    BRANCH_CALL_REGISTER,
    BRANCH_ERET
  } branch_type_t;

  // compare_is_vector marks a compare whose operands are vectors, so the
  // per-lane results must be packed into one scalar bit mask.
  typedef struct packed {
    logic         has_dest;
    logic [4:0]   dest_reg;
    logic         dest_is_vector;
    logic         is_compare;
    logic         compare_is_vector;
    logic         is_branch;
    branch_type_t branch_type;
    scalar_t      pc;
  } decoded_instruction_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_SX, SRC_MX, SRC_DD} wb_src_t;

endpackage

// File: rtl/writeback_stage.sv
// Final integer-pipeline stage.
// Selects one result per cycle from the single-cycle (sx), multi-cycle (mx)
// and data-cache (dd) stages, builds register-file write controls, owns the
// core-wide rollback and keeps per-thread retire counters.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   sx_* / mx_* / dd_*           registered upstream results
//   sx_rollback_*, sx_is_eret    taken branch / eret from single-cycle pipe
//   dd_rollback_*                cache miss / replay request
//   wb_rollback_*                registered flush request to all stages
//   wb_eret                      eret retired
//   wb_writeback_*               register-file write port
//   wb_retire_count              per-thread retired-instruction counters
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   sx_instruction_valid,
  input  decoded_instruction_t                   sx_instruction,
  input  vector_t                                sx_result,
  input  vector_mask_t                           sx_mask_value,
  input  thread_idx_t                            sx_thread_idx,
  input  logic                                   sx_rollback_en,
  input  scalar_t                                sx_rollback_pc,
  input  logic                                   sx_is_eret,
  input  logic                                   mx_instruction_valid,
  input  decoded_instruction_t                   mx_instruction,
  input  vector_t                                mx_result,
  input  vector_mask_t                           mx_mask_value,
  input  thread_idx_t                            mx_thread_idx,
  input  logic                                   dd_instruction_valid,
  input  decoded_instruction_t                   dd_instruction,
  input  vector_t                                dd_result,
  input  vector_mask_t                           dd_mask_value,
  input  thread_idx_t                            dd_thread_idx,
  input  logic                                   dd_rollback_en,
  input  scalar_t                                dd_rollback_pc,
  output logic                                   wb_rollback_en,
  output thread_idx_t                            wb_rollback_thread_idx,
  output scalar_t                                wb_rollback_pc,
  output logic                                   wb_eret,
  output logic                                   wb_writeback_en,
  output thread_idx_t                            wb_writeback_thread_idx,
  output logic                                   wb_writeback_is_vector,
  output logic [4:0]                             wb_writeback_reg,
  output vector_t                                wb_writeback_value,
  output vector_mask_t                           wb_writeback_mask,
  output logic [THREADS_PER_CORE-1:0][31:0]      wb_retire_count
);

  // Lane i's compare result lives in bit 0 of that lane; gather into bit i.
  function automatic scalar_t pack_compare(input vector_t r);
    scalar_t packed_bits;
    packed_bits = '0;
    for (int i = 0; i < VECTOR_LANES; i++) packed_bits[i] = r[i][0];
    return packed_bits;
  endfunction

  wb_src_t              sel_src;
  decoded_instruction_t sel_instr;
  vector_t              sel_result;
  vector_mask_t         sel_mask;
  thread_idx_t          sel_thread;

  logic         sx_squash, dd_replay, sx_rollback, retire, is_call;
  logic         rollback_en_d, write_d, eret_d, is_vector_d;
  thread_idx_t  rollback_thread_d;
  scalar_t      rollback_pc_d;
  vector_t      value_d;
  vector_mask_t mask_d;

  logic         rollback_en_q, eret_q, write_q, is_vector_q;
  thread_idx_t  rollback_thread_q, write_thread_q;
  scalar_t      rollback_pc_q;
  logic [4:0]   write_reg_q;
  vector_t      value_q;
  vector_mask_t mask_q;

  // Priority dd > mx > sx; issue normally never presents two at once.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    sel_src    = SRC_NONE;
    sel_instr  = sx_instruction;
    sel_result = sx_result;
    sel_mask   = sx_mask_value;
    sel_thread = sx_thread_idx;
    if (dd_instruction_valid) begin
      sel_src    = SRC_DD;
      sel_instr  = dd_instruction;
      sel_result = dd_result;
      sel_mask   = dd_mask_value;
      sel_thread = dd_thread_idx;
    end else if (mx_instruction_valid) begin
      sel_src    = SRC_MX;
      sel_instr  = mx_instruction;
      sel_result = mx_result;
      sel_mask   = mx_mask_value;
      sel_thread = mx_thread_idx;
    end else if (sx_instruction_valid) begin
      sel_src = SRC_SX;
    end
  end

  // The registered rollback always belongs to last cycle's instruction, so
  // it can never have been raised by the sx instruction now arriving.
  assign sx_squash   = (sel_src == SRC_SX) && rollback_en_q &&
                       (sx_thread_idx == rollback_thread_q);
  assign dd_replay   = (sel_src == SRC_DD) && dd_rollback_en;
  assign sx_rollback = (sel_src == SRC_SX) && sx_rollback_en && !sx_squash;
  assign retire      = (sel_src != SRC_NONE) && !sx_squash && !dd_replay;

  assign rollback_en_d = sx_rollback || dd_replay;
  assign write_d       = retire && sel_instr.has_dest;
  assign eret_d        = (sel_src == SRC_SX) && sx_is_eret && !sx_squash;
  assign is_call       = sel_instr.is_branch &&
                         (sel_instr.branch_type == BRANCH_CALL_OFFSET ||
                          sel_instr.branch_type == BRANCH_CALL_REGISTER);

  always_comb begin
    rollback_thread_d = rollback_thread_q;
    rollback_pc_d     = rollback_pc_q;
    if (dd_replay) begin
      rollback_thread_d = dd_thread_idx;
      rollback_pc_d     = dd_rollback_pc;
    end else if (sx_rollback) begin
      rollback_thread_d = sx_thread_idx;
      rollback_pc_d     = sx_rollback_pc;
    end
  end

  // Calls write the link address even though they also roll back.
  always_comb begin
    value_d     = '0;
    mask_d      = '1;
    is_vector_d = 1'b0;
    if (is_call) begin
      value_d[0] = sel_instr.pc + 32'd4;
    end else if (sel_instr.is_compare && sel_instr.compare_is_vector) begin
      value_d[0] = pack_compare(sel_result);
    end else if (sel_instr.dest_is_vector) begin
      value_d     = sel_result;
      mask_d      = sel_mask;
      is_vector_d = 1'b1;
    end else begin
      value_d[0] = sel_result[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rollback_en_q     <= 1'b0;
      rollback_thread_q <= '0;
      rollback_pc_q     <= '0;
      eret_q            <= 1'b0;
      write_q           <= 1'b0;
      write_thread_q    <= '0;
      is_vector_q       <= 1'b0;
      write_reg_q       <= '0;
      value_q           <= '0;
      mask_q            <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rollback_en_q     <= rollback_en_d;
      rollback_thread_q <= rollback_thread_d;
      rollback_pc_q     <= rollback_pc_d;
      eret_q            <= eret_d;
      write_q           <= write_d;
      if (write_d) begin
        write_thread_q <= sel_thread;
        is_vector_q    <= is_vector_d;
        write_reg_q    <= sel_instr.dest_reg;
        value_q        <= value_d;
        mask_q         <= mask_d;
      end
    end
  end

  for (genvar t = 0; t < THREADS_PER_CORE; t++) begin : g_retire
    logic [31:0] count_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                        count_q <= '0;
      else if (retire && sel_thread == thread_idx_t'(t))   count_q <= count_q + 32'd1;
    end
    assign wb_retire_count[t] = count_q;
  end

  assign wb_rollback_en          = rollback_en_q;
  assign wb_rollback_thread_idx  = rollback_thread_q;
  assign wb_rollback_pc          = rollback_pc_q;
  assign wb_eret                 = eret_q;
  assign wb_writeback_en         = write_q;
  assign wb_writeback_thread_idx = write_thread_q;
  assign wb_writeback_is_vector  = is_vector_q;
  assign wb_writeback_reg        = write_reg_q;
  assign wb_writeback_value      = value_q;
  assign wb_writeback_mask       = mask_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic sx_instruction_valid, mx_instruction_valid, dd_instruction_valid;
  decoded_instruction_t sx_instruction, mx_instruction, dd_instruction;
  vector_t sx_result, mx_result, dd_result;
  vector_mask_t sx_mask_value, mx_mask_value, dd_mask_value;
  thread_idx_t sx_thread_idx, mx_thread_idx, dd_thread_idx;
  logic sx_rollback_en, dd_rollback_en, sx_is_eret;
  scalar_t sx_rollback_pc, dd_rollback_pc;
  logic wb_rollback_en, wb_eret, wb_writeback_en, wb_writeback_is_vector;
  thread_idx_t wb_rollback_thread_idx, wb_writeback_thread_idx;
  scalar_t wb_rollback_pc;
  logic [4:0] wb_writeback_reg;
  vector_t wb_writeback_value;
  vector_mask_t wb_writeback_mask;
  logic [THREADS_PER_CORE-1:0][31:0] wb_retire_count;

  writeback_stage dut (
    .clk(clk), .reset_n(reset_n),
    .sx_instruction_valid(sx_instruction_valid), .sx_instruction(sx_instruction),
    .sx_result(sx_result), .sx_mask_value(sx_mask_value), .sx_thread_idx(sx_thread_idx),
    .sx_rollback_en(sx_rollback_en), .sx_rollback_pc(sx_rollback_pc), .sx_is_eret(sx_is_eret),
    .mx_instruction_valid(mx_instruction_valid), .mx_instruction(mx_instruction),
    .mx_result(mx_result), .mx_mask_value(mx_mask_value), .mx_thread_idx(mx_thread_idx),
    .dd_instruction_valid(dd_instruction_valid), .dd_instruction(dd_instruction),
    .dd_result(dd_result), .dd_mask_value(dd_mask_value), .dd_thread_idx(dd_thread_idx),
    .dd_rollback_en(dd_rollback_en), .dd_rollback_pc(dd_rollback_pc),
    .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
    .wb_rollback_pc(wb_rollback_pc), .wb_eret(wb_eret),
    .wb_writeback_en(wb_writeback_en), .wb_writeback_thread_idx(wb_writeback_thread_idx),
    .wb_writeback_is_vector(wb_writeback_is_vector), .wb_writeback_reg(wb_writeback_reg),
    .wb_writeback_value(wb_writeback_value), .wb_writeback_mask(wb_writeback_mask),
    .wb_retire_count(wb_retire_count)
  );

  always #5 clk = ~clk;

  // Issue guarantees at most one source per cycle.
  always @(posedge clk)
    if (reset_n === 1'b1)
      assert ($onehot0({sx_instruction_valid, mx_instruction_valid, dd_instruction_valid}))
        else $error("more than one result source valid");

  typedef struct {
    string        name;
    logic [1:0]   src;      // 0 none, 1 sx, 2 mx, 3 dd
    thread_idx_t  thr;
    logic         hd;
    logic [4:0]   rd;
    logic         dvec;
    logic         cmp;      // vector compare
    logic         br;
    branch_type_t bt;
    logic [31:0]  pc;
    logic [31:0]  seed;     // lane i = seed + i*0x100, bit0 from bits[i]
    logic [15:0]  bits;
    logic [15:0]  mask;
    logic         rb;
    logic [31:0]  rbpc;
    logic         eret;
    logic         e_wen;
    logic         e_vec;
    logic [31:0]  e_v0;
    logic [31:0]  e_v15;
    logic [15:0]  e_mask;
    logic         e_rb;
    logic [31:0]  e_rbpc;
    logic         e_eret;
    logic         e_ret;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [THREADS_PER_CORE-1:0][31:0] exp_cnt;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vector_t mk_result(input logic [31:0] seed, input logic [15:0] bits);
    vector_t r;
    for (int i = 0; i < VECTOR_LANES; i++)
      r[i] = ((seed + 32'(i) * 32'h100) & ~32'h1) | {31'b0, bits[i]};
    return r;
  endfunction

  task automatic drive(input vec_t v);
    decoded_instruction_t ins;
    vector_t r;
    ins = '0;
    ins.has_dest = v.hd;  ins.dest_reg = v.rd;  ins.dest_is_vector = v.dvec;
    ins.is_compare = v.cmp;  ins.compare_is_vector = v.cmp;
    ins.is_branch = v.br;  ins.branch_type = v.bt;  ins.pc = v.pc;
    r = mk_result(v.seed, v.bits);
    sx_instruction = ins;  mx_instruction = ins;  dd_instruction = ins;
    sx_result = r;  mx_result = r;  dd_result = r;
    sx_mask_value = v.mask;  mx_mask_value = v.mask;  dd_mask_value = v.mask;
    sx_thread_idx = v.thr;  mx_thread_idx = v.thr;  dd_thread_idx = v.thr;
    sx_instruction_valid = (v.src == 2'd1);
    mx_instruction_valid = (v.src == 2'd2);
    dd_instruction_valid = (v.src == 2'd3);
    sx_rollback_en = (v.src == 2'd1) && v.rb;
    dd_rollback_en = (v.src == 2'd3) && v.rb;
    sx_is_eret     = (v.src == 2'd1) && v.eret;
    sx_rollback_pc = v.rbpc;
    dd_rollback_pc = v.rbpc;
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input vec_t v);
    if (v.e_ret) exp_cnt[v.thr] = exp_cnt[v.thr] + 32'd1;
    check({v.name, ".wen"}, wb_writeback_en, v.e_wen);
    if (v.e_wen) begin
      check({v.name, ".reg"},  wb_writeback_reg, v.rd);
      check({v.name, ".thr"},  wb_writeback_thread_idx, v.thr);
      check({v.name, ".isvec"}, wb_writeback_is_vector, v.e_vec);
      check({v.name, ".v0"},   wb_writeback_value[0], v.e_v0);
      check({v.name, ".mask"}, wb_writeback_mask, v.e_mask);
      if (v.e_vec) check({v.name, ".v15"}, wb_writeback_value[15], v.e_v15);
    end
    check({v.name, ".rb"}, wb_rollback_en, v.e_rb);
    if (v.e_rb) check({v.name, ".rbthr"}, wb_rollback_thread_idx, v.thr);
    check({v.name, ".rbpc"},   wb_rollback_pc, v.e_rbpc);
    check({v.name, ".eret"},   wb_eret, v.e_eret);
    check({v.name, ".retire"}, wb_retire_count, exp_cnt);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".wen"},   wb_writeback_en, 0);
    check({name, ".rb"},    wb_rollback_en, 0);
    check({name, ".rbpc"},  wb_rollback_pc, 0);
    check({name, ".rbthr"}, wb_rollback_thread_idx, 0);
    check({name, ".eret"},  wb_eret, 0);
    check({name, ".reg"},   wb_writeback_reg, 0);
    check({name, ".value"}, wb_writeback_value, 0);
    check({name, ".mask"},  wb_writeback_mask, 0);
    check({name, ".isvec"}, wb_writeback_is_vector, 0);
    check({name, ".retire"}, wb_retire_count, 0);
  endtask

  vec_t vecs[$];
  vec_t sq[$];
  vec_t idle_v;
  vec_t v;

  initial begin
    // Field order: name, src, thr, hd, rd, dvec, cmp, br, bt, pc, seed, bits, mask, rb, rbpc, eret,
    //              e_wen, e_vec, e_v0, e_v15, e_mask, e_rb, e_rbpc, e_eret, e_ret
    idle_v = '{"idle", 0, 0, 0, 0, 0, 0, 0, BRANCH_COND_ZERO, 32'h0, 32'h0, 16'h0, 16'h0, 0, 32'h0, 0,
               0, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0, 0, 0};

    vecs.push_back('{"scalar_add", 1, 1, 1, 3, 0, 0, 0, BRANCH_COND_ZERO, 32'h10, 32'h1234, 16'h0, 16'h00ff, 0, 32'h0, 0,
                     1, 0, 32'h1234, 32'h0, 16'hffff, 0, 32'h0, 0, 1});
    vecs.push_back('{"call", 1, 2, 1, 31, 0, 0, 1, BRANCH_CALL_OFFSET, 32'h100, 32'h5000, 16'h0, 16'h0, 1, 32'h200, 0,
                     1, 0, 32'h104, 32'h0, 16'hffff, 1, 32'h200, 0, 1});
    vecs.push_back('{"vec_cmp", 2, 0, 1, 7, 0, 1, 0, BRANCH_COND_ZERO, 32'h20, 32'h4000, 16'h8005, 16'h0f0f, 0, 32'h0, 0,
                     1, 0, 32'h8005, 32'h0, 16'hffff, 0, 32'h200, 0, 1});
    vecs.push_back('{"vec_write", 3, 3, 1, 9, 1, 0, 0, BRANCH_COND_ZERO, 32'h30, 32'h0a00, 16'h0001, 16'h3c3c, 0, 32'h0, 0,
                     1, 1, 32'h0a01, 32'h1900, 16'h3c3c, 0, 32'h200, 0, 1});
    vecs.push_back('{"cache_miss", 3, 0, 1, 4, 0, 0, 0, BRANCH_COND_ZERO, 32'h400, 32'h7770, 16'h0, 16'hffff, 1, 32'h400, 0,
                     0, 0, 32'h0, 32'h0, 16'h0, 1, 32'h400, 0, 0});
    vecs.push_back('{"eret", 1, 3, 0, 0, 0, 0, 1, BRANCH_ERET, 32'h50, 32'h0, 16'h0, 16'h0, 1, 32'h80, 1,
                     0, 0, 32'h0, 32'h0, 16'h0, 1, 32'h80, 1, 1});
    vecs.push_back('{"mx_no_dest", 2, 1, 0, 0, 0, 0, 0, BRANCH_COND_ZERO, 32'h60, 32'h10, 16'h0, 16'h0, 0, 32'h0, 0,
                     0, 0, 32'h0, 32'h0, 16'h0, 0, 32'h80, 0, 1});
    vecs.push_back('{"sx_vector", 1, 2, 1, 12, 1, 0, 0, BRANCH_COND_ZERO, 32'h70, 32'h2220, 16'hffff, 16'ha5a5, 0, 32'h0, 0,
                     1, 1, 32'h2221, 32'h3121, 16'ha5a5, 0, 32'h80, 0, 1});
    vecs.push_back('{"call_reg", 1, 0, 1, 31, 0, 0, 1, BRANCH_CALL_REGISTER, 32'hfffc, 32'h0, 16'h0, 16'h0, 1, 32'h1000, 0,
                     1, 0, 32'h10000, 32'h0, 16'hffff, 1, 32'h1000, 0, 1});
    vecs.push_back('{"dd_load", 3, 2, 1, 6, 0, 0, 0, BRANCH_COND_ZERO, 32'h90, 32'hbeef0, 16'h0, 16'h0, 0, 32'h0, 0,
                     1, 0, 32'hbeef0, 32'h0, 16'hffff, 0, 32'h1000, 0, 1});

    // Back-to-back pairs: a taken branch followed by a result on the same or another thread.
    sq.push_back('{"sq_branch", 1, 0, 0, 0, 0, 0, 1, BRANCH_ALWAYS, 32'h500, 32'h0, 16'h0, 16'h0, 1, 32'h600, 0,
                   0, 0, 32'h0, 32'h0, 16'h0, 1, 32'h600, 0, 1});
    sq.push_back('{"sq_victim", 1, 0, 1, 5, 0, 0, 0, BRANCH_COND_ZERO, 32'h504, 32'h5550, 16'h0, 16'h0, 1, 32'h900, 1,
                   0, 0, 32'h0, 32'h0, 16'h0, 0, 32'h600, 0, 0});
    sq.push_back('{"sq_idle", 0, 0, 0, 0, 0, 0, 0, BRANCH_COND_ZERO, 32'h0, 32'h0, 16'h0, 16'h0, 0, 32'h0, 0,
                   0, 0, 32'h0, 32'h0, 16'h0, 0, 32'h600, 0, 0});
    sq.push_back('{"sq_branch2", 1, 0, 0, 0, 0, 0, 1, BRANCH_ALWAYS, 32'h500, 32'h0, 16'h0, 16'h0, 1, 32'h600, 0,
                   0, 0, 32'h0, 32'h0, 16'h0, 1, 32'h600, 0, 1});
    sq.push_back('{"sq_other_thr", 1, 1, 1, 5, 0, 0, 0, BRANCH_COND_ZERO, 32'h700, 32'h5550, 16'h0, 16'h0, 0, 32'h0, 0,
                   1, 0, 32'h5550, 32'h0, 16'hffff, 0, 32'h600, 0, 1});
    sq.push_back('{"sq_branch_t1", 1, 1, 0, 0, 0, 0, 1, BRANCH_ALWAYS, 32'h704, 32'h0, 16'h0, 16'h0, 1, 32'h640, 0,
                   0, 0, 32'h0, 32'h0, 16'h0, 1, 32'h640, 0, 1});
    sq.push_back('{"sq_mx_t1", 2, 1, 1, 8, 0, 0, 0, BRANCH_COND_ZERO, 32'h708, 32'h8880, 16'h0, 16'h0, 0, 32'h0, 0,
                   1, 0, 32'h8880, 32'h0, 16'hffff, 0, 32'h640, 0, 1});
    sq.push_back('{"sq_branch_t2", 1, 2, 0, 0, 0, 0, 1, BRANCH_ALWAYS, 32'h800, 32'h0, 16'h0, 16'h0, 1, 32'h680, 0,
                   0, 0, 32'h0, 32'h0, 16'h0, 1, 32'h680, 0, 1});
    sq.push_back('{"sq_dd_t2", 3, 2, 1, 10, 0, 0, 0, BRANCH_COND_ZERO, 32'h804, 32'h9990, 16'h0, 16'h0, 0, 32'h0, 0,
                   1, 0, 32'h9990, 32'h0, 16'hffff, 0, 32'h680, 0, 1});

    exp_cnt = '0;

    // Reset held with a valid sx result on the inputs.
    reset_n = 1'b0;
    v = '{"rst_add", 1, 0, 1, 1, 0, 0, 0, BRANCH_COND_ZERO, 32'h4, 32'h42, 16'h0, 16'h0, 0, 32'h0, 0,
          1, 0, 32'h42, 32'h0, 16'hffff, 0, 32'h0, 0, 1};
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_release.no_comb", wb_writeback_en, 0);
    @(posedge clk);
    #1;
    check_vec(v);
    apply_vec(idle_v);

    foreach (vecs[i]) begin
      apply_vec(vecs[i]);
      check_vec(vecs[i]);
      apply_vec(idle_v);
    end

    foreach (sq[i]) begin
      apply_vec(sq[i]);
      check_vec(sq[i]);
    end
    apply_vec(idle_v);

    // Asynchronous reset in the middle of a cycle with a write pending on the outputs.
    v = '{"mid_add", 1, 1, 1, 2, 0, 0, 0, BRANCH_COND_ZERO, 32'ha0, 32'h3330, 16'h0, 16'h0, 1, 32'hb00, 0,
          1, 0, 32'h3330, 32'h0, 16'hffff, 1, 32'hb00, 0, 1};
    apply_vec(v);
    check_vec(v);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_cnt = '0;
    @(negedge clk);
    drive(idle_v);
    reset_n = 1'b1;

    // Counter wrap: preset thread 3 to all ones, then retire one instruction on it.
    @(negedge clk);
    dut.g_retire[3].count_q = 32'hffffffff;
    exp_cnt[3] = 32'hffffffff;
    @(posedge clk);
    #1;
    check("wrap.preset", wb_retire_count, exp_cnt);
    v = '{"wrap", 1, 3, 0, 0, 0, 0, 0, BRANCH_COND_ZERO, 32'hc0, 32'h0, 16'h0, 16'h0, 0, 32'h0, 0,
          0, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0, 0, 1};
    apply_vec(v);
    check_vec(v);
    check("wrap.count3", wb_retire_count[3], 32'h0);
    apply_vec(idle_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
